// File: rtl/uart_sender.sv
// uart_sender: byte FIFO feeding an 8N1 serial transmitter (LSB first, idle-high line).
module uart_sender #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       sender_ready,
  output logic       txd,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [CntW-1:0] BaudLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [PtrW:0]   FullCnt  = (PtrW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // FIFO storage and bookkeeping; occupancy is kept apart from the pointers so that
  // full and empty remain distinguishable when the pointers coincide.
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            push, pop, fifo_empty;

  // Transmitter state.
  state_e          state_q;
  logic [CntW-1:0] baud_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            txd_q;
  // Tracks the cycle where txd still shows the stop bit after the FSM has gone idle.
  logic            line_active_q;
  logic            baud_wrap;

  assign sender_ready = (count_q < FullCnt);
  assign push         = valid & sender_ready;
  assign fifo_empty   = (count_q == '0);
  assign baud_wrap    = (baud_q == BaudLast);

  assign txd  = txd_q;
  assign busy = (state_q != StIdle) | ~fifo_empty | line_active_q;

  // Pop whenever the FSM is ready for a new byte: from idle, or at the end of a stop bit.
  always_comb begin
    pop = 1'b0;
    if (!fifo_empty) begin
      if (state_q == StIdle) begin
        pop = 1'b1;
      end else if ((state_q == StStop) && baud_wrap) begin
        pop = 1'b1;
      end
    end
  end

  // Next-state for FIFO pointers and occupancy; push and pop may coincide.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO pointer and occupancy registers.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO data array; contents are don't-care until written, so no reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= data;
    end
  end

  // Transmit FSM; txd is registered from the current state, so it trails the state by one cycle.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      baud_q        <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      txd_q         <= 1'b1;
      line_active_q <= 1'b0;
    end else begin
      line_active_q <= (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          txd_q     <= 1'b1;
          baud_q    <= '0;
          bit_idx_q <= '0;
          if (pop) begin
            shift_q <= mem_q[rd_ptr_q];
            state_q <= StStart;
          end
        end
        StStart: begin
          txd_q <= 1'b0;
          if (baud_wrap) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            state_q   <= StData;
          end else begin
            baud_q <= baud_q + CntW'(1);
          end
        end
        StData: begin
          txd_q <= shift_q[bit_idx_q];
          if (baud_wrap) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
              bit_idx_q <= '0;
              state_q   <= StStop;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + CntW'(1);
          end
        end
        StStop: begin
          txd_q <= 1'b1;
          if (baud_wrap) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            // Chain straight into the next start bit when more data is queued.
            if (pop) begin
              shift_q <= mem_q[rd_ptr_q];
              state_q <= StStart;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            baud_q <= baud_q + CntW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_sender.sv
// tb_uart_sender: directed scenarios for uart_sender with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_uart_sender;

  localparam int Cpb   = 4;
  localparam int Depth = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data  = 8'h00;
  logic       valid = 1'b0;
  logic       ready;
  logic       txd;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  uart_sender #(
    .CLKS_PER_BIT(Cpb),
    .FIFO_DEPTH  (Depth)
  ) dut (
    .CLK         (clk),
    .reset       (rst_n),
    .data        (data),
    .valid       (valid),
    .sender_ready(ready),
    .txd         (txd),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Edge counter: read #1 after a rising edge it holds that edge's number.
  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: captures 40 negedge samples per frame, starting at the first low sample.
  logic [39:0] fr_raw_q[$];
  int          fr_start_q[$];

  initial begin
    logic [39:0] raw;
    int cnt, start;
    cnt = 0;
    raw = '0;
    start = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cnt = 0;
      end else if (cnt == 0) begin
        if (txd === 1'b0) begin
          raw = '0;
          start = cyc;
          cnt = 1;
        end
      end else begin
        raw[cnt] = txd;
        cnt++;
        if (cnt == 40) begin
          fr_raw_q.push_back(raw);
          fr_start_q.push_back(start);
          cnt = 0;
        end
      end
    end
  end

  function automatic logic [7:0] fr_byte(input logic [39:0] r);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = r[4 * i + 6];
    return b;
  endfunction

  // True when start is low, stop is high and every bit is held for all four samples.
  function automatic bit fr_clean(input logic [39:0] r);
    bit ok;
    ok = (r[3:0] == 4'h0) && (r[39:36] == 4'hF);
    for (int i = 0; i < 8; i++) if (r[4 * i + 4 +: 4] != {4{r[4 * i + 6]}}) ok = 0;
    return ok;
  endfunction

  task automatic get_frame(output logic [39:0] raw, output int start, output bit got);
    raw = '0;
    start = 0;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      if (fr_raw_q.size() != 0) begin
        raw = fr_raw_q.pop_front();
        start = fr_start_q.pop_front();
        got = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Present a byte and hold it until accepted; returns the accepting edge number.
  task automatic push(input logic [7:0] b, output int edge_n);
    valid = 1'b1;
    data = b;
    edge_n = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        @(posedge clk);
        #1;
        edge_n = cyc;
        break;
      end
    end
    valid = 1'b0;
    if (edge_n < 0) begin
      vectors++;
      miscompares++;
      $display("FAIL push_timeout byte=%02h never accepted", b);
    end
  endtask

  task automatic wait_idle();
    int i;
    i = 0;
    while (busy !== 1'b0 && i < 2000) begin
      @(negedge clk);
      i++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_timeout busy=%b want 0", busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    valid = 1'b1;
    data = 8'hEE;
    repeat (3) @(negedge clk);
    vectors++;
    if (txd !== 1'b1) begin miscompares++; $display("FAIL reset_txd got %b want 1", txd); end
    vectors++;
    if (ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", ready); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    logic [39:0] raw, exp_raw;
    logic [9:0] seq;
    int n, st, fall, bfall;
    bit got;
    seq = 10'b1101001010;  // start, a5 LSB first, stop
    for (int k = 0; k < 40; k++) exp_raw[k] = seq[k / 4];
    push(8'hA5, n);
    fall = -1;
    bfall = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fall < 0 && txd === 1'b0) fall = cyc;
      if (fall >= 0 && bfall < 0 && busy === 1'b0) bfall = cyc;
    end
    vectors++;
    if (fall != n + 2) begin miscompares++; $display("FAIL single_latency got %0d want %0d", fall - n, 2); end
    vectors++;
    if (bfall - fall != 40) begin
      miscompares++; $display("FAIL single_busy_fall got %0d want 40", bfall - fall);
    end
    get_frame(raw, st, got);
    vectors++;
    if (!got) begin miscompares++; $display("FAIL single_frame got none want 1 frame"); end
    vectors++;
    if (raw !== exp_raw) begin
      miscompares++; $display("FAIL single_bits got %010h want %010h", raw, exp_raw);
    end
    wait_idle();
  endtask

  task automatic test_back_to_back();
    logic [39:0] raw;
    logic [7:0] exp_b [3];
    int n0, n, st, prev;
    bit got;
    exp_b[0] = 8'h00;
    exp_b[1] = 8'hFF;
    exp_b[2] = 8'h55;
    push(exp_b[0], n0);
    push(exp_b[1], n);
    push(exp_b[2], n);
    prev = n0 - 38;
    for (int i = 0; i < 3; i++) begin
      get_frame(raw, st, got);
      vectors++;
      if (!got || fr_byte(raw) !== exp_b[i] || !fr_clean(raw)) begin
        miscompares++;
        $display("FAIL b2b_byte%0d got %02h clean=%0d want %02h", i, fr_byte(raw), fr_clean(raw),
                 exp_b[i]);
      end
      vectors++;
      if (st - prev != 40) begin
        miscompares++; $display("FAIL b2b_gap%0d got %0d want 40", i, st - prev);
      end
      prev = st;
    end
    wait_idle();
  endtask

  task automatic test_full_fifo();
    logic [39:0] raw;
    int st;
    bit got;
    valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data = 8'(8'h10 + i);
      if (i == 4) begin
        vectors++;
        if (ready !== 1'b1) begin miscompares++; $display("FAIL full_ready3 got %b want 1", ready); end
      end
      if (i == 5) begin
        vectors++;
        if (ready !== 1'b0) begin miscompares++; $display("FAIL full_ready4 got %b want 0", ready); end
      end
      @(posedge clk);
      #1;
    end
    valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      get_frame(raw, st, got);
      vectors++;
      if (!got || fr_byte(raw) !== 8'(8'h10 + i) || !fr_clean(raw)) begin
        miscompares++;
        $display("FAIL full_order%0d got %02h want %02h", i, fr_byte(raw), 8'(8'h10 + i));
      end
    end
    wait_idle();
    vectors++;
    if (fr_raw_q.size() != 0) begin
      miscompares++; $display("FAIL full_extra got %0d frames want 0", fr_raw_q.size());
    end
  endtask

  task automatic test_simul_push_pop();
    logic [39:0] raw;
    logic [7:0] exp_b [6];
    int n, m, st;
    bit got;
    exp_b = '{8'h81, 8'h42, 8'h24, 8'h99, 8'hC3, 8'h3E};
    push(exp_b[0], n);
    push(exp_b[1], m);
    push(exp_b[2], m);
    while (cyc < n + 40) begin @(posedge clk); #1; end
    // Edge n+41 ends the first stop bit: pop and push together.
    valid = 1'b1;
    data = exp_b[3];
    @(posedge clk);
    #1;
    data = exp_b[4];
    vectors++;
    if (ready !== 1'b1) begin miscompares++; $display("FAIL simul_occ2 ready got %b want 1", ready); end
    @(posedge clk);
    #1;
    data = exp_b[5];
    @(posedge clk);
    #1;
    valid = 1'b0;
    vectors++;
    if (ready !== 1'b0) begin miscompares++; $display("FAIL simul_occ4 ready got %b want 0", ready); end
    for (int i = 0; i < 6; i++) begin
      get_frame(raw, st, got);
      vectors++;
      if (!got || fr_byte(raw) !== exp_b[i] || !fr_clean(raw)) begin
        miscompares++;
        $display("FAIL simul_order%0d got %02h want %02h", i, fr_byte(raw), exp_b[i]);
      end
    end
    wait_idle();
  endtask

  task automatic test_mid_reset();
    logic [39:0] raw;
    int n, m, st;
    bit got;
    push(8'hA5, n);
    push(8'h66, m);
    while (cyc < n + 19) begin @(posedge clk); #1; end
    vectors++;
    if (txd !== 1'b0) begin miscompares++; $display("FAIL midrst_bit3 got %b want 0", txd); end
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (txd !== 1'b1) begin miscompares++; $display("FAIL midrst_txd got %b want 1", txd); end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got %b want 0", busy); end
    vectors++;
    if (ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready got %b want 1", ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    valid = 1'b1;
    data = 8'h3C;
    @(posedge clk);
    #1;
    valid = 1'b0;
    m = cyc;
    get_frame(raw, st, got);
    vectors++;
    if (!got || fr_byte(raw) !== 8'h3C || !fr_clean(raw)) begin
      miscompares++; $display("FAIL midrst_frame got %02h want 3c", fr_byte(raw));
    end
    vectors++;
    if (st != m + 2) begin miscompares++; $display("FAIL midrst_latency got %0d want 2", st - m); end
    wait_idle();
    vectors++;
    if (fr_raw_q.size() != 0) begin
      miscompares++; $display("FAIL midrst_discard got %0d frames want 0", fr_raw_q.size());
    end
  endtask

  task automatic test_wrap();
    logic [39:0] raw;
    int n, st;
    bit got;
    for (int i = 1; i <= 9; i++) push(8'(i), n);
    for (int i = 1; i <= 9; i++) begin
      get_frame(raw, st, got);
      vectors++;
      if (!got || fr_byte(raw) !== 8'(i) || !fr_clean(raw)) begin
        miscompares++; $display("FAIL wrap_byte%0d got %02h want %02h", i, fr_byte(raw), 8'(i));
      end
    end
    wait_idle();
    vectors++;
    if (fr_raw_q.size() != 0) begin
      miscompares++; $display("FAIL wrap_extra got %0d frames want 0", fr_raw_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_fifo();
    test_simul_push_pop();
    test_mid_reset();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog sim time expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_sender.md
UART_SENDER -- requirements
Module: uart_sender

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per serial bit (100 MHz / 115200), legal range >= 2.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, byte FIFO entries, power of two, >= 2.
REQ-003 The block SHALL have port CLK  input  1  system clock; all state changes on rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port data  input  8  byte to transmit.
REQ-006 The block SHALL have port valid  input  1  data is presented for transfer.
REQ-007 The block SHALL have port sender_ready  output  1  block can accept a byte this cycle.
REQ-008 The block SHALL have port txd  output  1  serial line, 8N1, idle high.
REQ-009 The block SHALL have port busy  output  1  frame in progress or FIFO non-empty.

Function
REQ-010 The block SHALL accept a byte on a rising edge where valid=1 and sender_ready=1, and SHALL not accept a byte otherwise.
REQ-011 The block SHALL drive sender_ready combinationally as 1 exactly when FIFO occupancy < FIFO_DEPTH.
REQ-012 The block SHALL store accepted bytes in a FIFO_DEPTH-entry FIFO, in acceptance order.
REQ-013 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be tracked separately so that full and empty are distinguishable.
REQ-014 On a simultaneous push and pop, the block SHALL perform both and SHALL leave occupancy unchanged.
REQ-015 A push attempted while full SHALL be ignored, with no pointer or data change.
REQ-016 The FSM SHALL have states IDLE, START, DATA and STOP, with a baud counter of $clog2(CLKS_PER_BIT) bits and a 3-bit bit index.
REQ-017 In IDLE with the FIFO non-empty, the FSM SHALL pop the head byte into a shift register, clear the baud counter and enter START.
REQ-018 In IDLE with the FIFO empty, the FSM SHALL remain in IDLE with txd=1.
REQ-019 In START, txd SHALL be 0 for exactly CLKS_PER_BIT cycles, then the FSM SHALL enter DATA with bit index 0.
REQ-020 In DATA, txd SHALL output shift register bit[index], LSB first, for CLKS_PER_BIT cycles per bit; after bit 7 the FSM SHALL enter STOP.
REQ-021 In STOP, txd SHALL be 1 for CLKS_PER_BIT cycles.
REQ-022 At the end of STOP, the FSM SHALL pop the next byte and go directly to START if the FIFO is non-empty, with no idle gap; otherwise it SHALL go to IDLE.
REQ-023 The baud counter SHALL count 0..CLKS_PER_BIT-1, wrap to 0 at each bit boundary, and advance the bit or state on wrap.
REQ-024 txd SHALL be driven from a register with no combinational path from inputs.
REQ-025 Latency: for a byte accepted at edge N into an empty FIFO with the FSM in IDLE, txd SHALL fall at edge N+2.
REQ-026 Each frame SHALL last exactly 10*CLKS_PER_BIT cycles.
REQ-027 busy SHALL be 1 when state != IDLE or occupancy != 0.

Reset
REQ-028 While reset=0, regardless of clock, the block SHALL force txd=1, FSM=IDLE, FIFO empty (pointers and occupancy 0), baud counter 0, bit index 0, shift register 0.
REQ-029 While reset=0, the outputs SHALL be sender_ready=1 and busy=0.
REQ-030 A reset asserted mid-frame SHALL abort the frame immediately (txd high) and SHALL discard all queued bytes.
REQ-031 The first byte SHALL be accepted on the first rising edge after reset deasserts.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-032 Bench SHALL cover single byte: push 0xA5 at edge N -> txd falls at N+2, bit sequence 0,1,0,1,0,0,1,0,1,1 with 4 cycles each, busy falls 40 cycles after txd fell.
REQ-033 Bench SHALL cover back-to-back: push 0x00,0xFF,0x55 consecutively -> three contiguous 40-cycle frames with no idle cycles between stop and start.
REQ-034 Bench SHALL cover full FIFO: with valid held high, push 6 bytes -> sender_ready=0 once 4 bytes are queued (1 byte in flight), extra push ignored, all accepted bytes emitted in order.
REQ-035 Bench SHALL cover simultaneous push/pop: push at the STOP-final cycle with occupancy 2 -> occupancy stays 2, order preserved.
REQ-036 Bench SHALL cover mid-frame reset: assert reset during DATA bit 3 -> txd=1 asynchronously, busy=0, sender_ready=1; after release, a new 0x3C frame is transmitted correctly.
REQ-037 Bench SHALL cover pointer wrap: stream 9 bytes 0x01..0x09 -> output order 0x01..0x09 exactly, with no duplication or loss.
